// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receiver and its
// receive FIFO.
package uart_rx_pkg;

    localparam int MIN_LEN      = 5;
    localparam int MIN_PRESCALE = 8;

    // Width of the data field carried by every FIFO entry.
    localparam int ENTRY_DATA_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        logic                    par_err;
        logic                    stp_err;
    } rx_entry_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO of receive entries with a sticky overrun flag.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  rx_entry_t wr_entry,
    input  logic      pop,
    input  logic      ovr_clr,
    output rx_entry_t head,
    output logic      not_empty,
    output logic      full,
    output logic      ovr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovr_q, ovr_d;
    rx_entry_t   mem_q [DEPTH];

    logic empty;
    logic pop_en;
    logic push_en;
    logic overrun;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_en  = pop && !empty;
        // A pop in the same cycle frees the slot the push lands in.
        push_en = push && (!full || pop_en);
        overrun = push && full && !pop_en;

        wr_ptr_d = push_en ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop_en  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

        ovr_d = ovr_q;
        if (overrun) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // Empty FIFO presents an all-zero head so outputs are defined after reset.
    assign head      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign not_empty = !empty;
    assign ovr       = ovr_q;

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver with runtime frame format, 3-sample majority bit decisions,
// input synchroniser and a show-ahead receive FIFO.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int PRESCALE_W = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [3:0]            DATA_LEN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STP2,
    input  logic                  RD_EN,
    input  logic                  OVR_CLR,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  DATA_VALID,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  FIFO_FULL,
    output logic                  OVR
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]            smp_q, smp_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic [3:0]            len_q, len_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stp2_q, stp2_d;

    logic                  rx_s;
    logic                  active;
    logic                  wrap;
    logic                  bit_rdy;
    logic                  bit_val;
    logic [PRESCALE_W-1:0] half;
    logic                  push;
    rx_entry_t             wr_entry;
    rx_entry_t             head;

    always_comb begin
        sync1_d = RX_IN;
        sync2_d = sync1_q;
        rx_s    = sync2_q;

        half    = Prescale >> 1;
        active  = (state_q != IDLE);
        wrap    = active && (edge_cnt_q == Prescale - ONE);
        // The decision is the majority of the three registered mid-bit samples.
        bit_rdy = active && (edge_cnt_q == half + TWO);
        bit_val = maj3(smp_q);

        edge_cnt_d = (!active || wrap) ? '0 : edge_cnt_q + ONE;
        smp_d      = smp_q;
        if (active && (edge_cnt_q == half - ONE || edge_cnt_q == half ||
                       edge_cnt_q == half + ONE)) begin
            smp_d = {smp_q[1:0], rx_s};
        end

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stp2_d     = stp2_q;
        push       = 1'b0;
        wr_entry   = '0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    len_d      = DATA_LEN;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    stp2_d     = STP2;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    shift_d    = '0;
                    perr_d     = 1'b0;
                    serr_d     = 1'b0;
                end
            end
            START: begin
                if (bit_rdy && bit_val) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_rdy) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_cnt_q == 4'(i)) begin
                            shift_d[i] = bit_val;
                        end
                    end
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (wrap && bit_cnt_q == len_q) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_rdy) begin
                    perr_d = (^shift_q) ^ bit_val ^ par_typ_q;
                end
                if (wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_rdy) begin
                    if (stp2_q && !stop_cnt_q) begin
                        serr_d = serr_q | ~bit_val;
                    end else begin
                        // Last stop decided: push now and skip the bit tail.
                        push             = 1'b1;
                        wr_entry.data    = ENTRY_DATA_W'(shift_q);
                        wr_entry.par_err = perr_q;
                        wr_entry.stp_err = serr_q | ~bit_val;
                        state_d          = IDLE;
                        edge_cnt_d       = '0;
                    end
                end
                if (wrap) begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            smp_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stp2_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            smp_q      <= smp_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stp2_q     <= stp2_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (RD_EN),
        .ovr_clr  (OVR_CLR),
        .head     (head),
        .not_empty(DATA_VALID),
        .full     (FIFO_FULL),
        .ovr      (OVR)
    );

    assign P_DATA  = DATA_W'(head.data);
    assign par_err = head.par_err;
    assign stp_err = head.stp_err;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomised frames for uart_rx_param, checked against a
// frame-level model of the receive FIFO contents and overrun flag.
module tb_uart_rx_param;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic [3:0] data_len;
    logic       par_en;
    logic       par_typ;
    logic       stp2;
    logic       rd_en;
    logic       ovr_clr;
    logic [8:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       fifo_full;
    logic       ovr;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each entry is {data[8:0], par_err, stp_err}.
    logic [10:0] exp_q[$];
    logic        exp_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_W(9),
        .PRESCALE_W(6),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .RX_IN     (rx_in),
        .Prescale  (prescale),
        .DATA_LEN  (data_len),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .STP2      (stp2),
        .RD_EN     (rd_en),
        .OVR_CLR   (ovr_clr),
        .P_DATA    (p_data),
        .DATA_VALID(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err),
        .FIFO_FULL (fifo_full),
        .OVR       (ovr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [10:0] e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovr = 1'b1;
    endtask

    // Drives one frame; glitch_bit >= 0 puts a 1-cycle inverted pulse at the
    // middle of that data bit.
    task automatic send_frame(input logic [8:0] data, input int len, input bit pen,
                              input bit ptyp, input bit s2, input int p, input bit badp,
                              input bit st1, input bit st2, input int glitch_bit,
                              input bit do_model);
        logic [15:0] fb;
        logic [8:0]  d;
        int          n;
        d        = data & 9'((1 << len) - 1);
        data_len = 4'(len);
        par_en   = pen;
        par_typ  = ptyp;
        stp2     = s2;
        prescale = 6'(p);
        fb       = '0;
        n        = 1;
        for (int i = 0; i < len; i++) begin
            fb[n] = d[i];
            n++;
        end
        if (pen) begin
            fb[n] = (^d) ^ ptyp ^ badp;
            n++;
        end
        fb[n] = st1;
        n++;
        if (s2) begin
            fb[n] = st2;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                rx_in = (glitch_bit >= 0 && b == glitch_bit + 1 && c == p / 2) ? ~fb[b] : fb[b];
                tick();
            end
        end
        rx_in = 1'b1;
        if (do_model) model_push({d, pen & badp, ~st1 | (s2 & ~st2)});
    endtask

    task automatic check_head(input string tag);
        check({tag, "_valid"}, 32'(data_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check({tag, "_head"}, 32'({p_data, par_err, stp_err}), 32'(exp_q[0]));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        logic [8:0] rd;
        int         len, p;
        bit         pen, ptyp, s2, badp, st1, st2;

        rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; data_len = 4'd8;
        par_en = 1'b0; par_typ = 1'b0; stp2 = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
        repeat (3) tick();
        check("rst_p_data", 32'(p_data), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_par_err", 32'(par_err), 0);
        check("rst_stp_err", 32'(stp_err), 0);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_ovr", 32'(ovr), 0);
        rst = 1'b0;
        repeat (4) tick();

        // 8N1 at Prescale 8.
        send_frame(9'h0A5, 8, 0, 0, 0, 8, 0, 1, 1, -1, 1);
        repeat (8) tick();
        check_head("8n1_a5");
        check("8n1_empty", 32'(data_valid), 0);

        // 7E2 at Prescale 16 with wrong parity, then with a bad second stop.
        send_frame(9'h035, 7, 1, 0, 1, 16, 1, 1, 1, -1, 1);
        repeat (16) tick();
        check_head("7e2_badpar");
        send_frame(9'h035, 7, 1, 0, 1, 16, 0, 1, 0, -1, 1);
        repeat (16) tick();
        check_head("7e2_badstop");

        // 9O1 at Prescale 32 with a one-cycle low pulse inside data bit 4.
        send_frame(9'h1FF, 9, 1, 1, 0, 32, 0, 1, 1, 4, 1);
        repeat (32) tick();
        check_head("9o1_glitch");

        // Short low pulse on an idle line is rejected as a start glitch.
        prescale = 6'd8;
        rx_in = 1'b0;
        repeat (2) tick();
        rx_in = 1'b1;
        repeat (24) tick();
        check("start_glitch_valid", 32'(data_valid), 0);

        // Randomised frame formats, prescales and error injections.
        for (int k = 0; k < 10; k++) begin
            rd   = 9'($urandom_range(0, 511));
            len  = $urandom_range(5, 9);
            p    = 2 * $urandom_range(4, 16);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            s2   = 1'($urandom_range(0, 1));
            badp = 1'($urandom_range(0, 3) == 0);
            st1  = 1'($urandom_range(0, 3) != 0);
            st2  = 1'($urandom_range(0, 3) != 0);
            send_frame(rd, len, pen, ptyp, s2, p, badp, st1, st2, -1, 1);
            repeat (p) tick();
            check_head("rand");
        end

        // FIFO_DEPTH+1 back-to-back 5N1 frames without reading.
        for (int k = 0; k < DEPTH + 1; k++) begin
            send_frame(9'($urandom_range(0, 31)), 5, 0, 0, 0, 8, 0, 1, 1, -1, 1);
        end
        repeat (8) tick();
        check("ovf_full", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
        check("ovf_ovr", 32'(ovr), 32'(exp_ovr));
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        check("ovr_clr", 32'(ovr), 32'(exp_ovr));

        // Push and pop in the same cycle while full: RD_EN lands in the
        // cycle that holds the last stop decision.
        rd = 9'($urandom_range(0, 31));
        fork
            send_frame(rd, 5, 0, 0, 0, 8, 0, 1, 1, -1, 0);
            begin
                repeat (57) tick();
                rd_en = 1'b1;
                tick();
                rd_en = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        model_push({rd, 2'b00});
        repeat (8) tick();
        check("pushpop_ovr", 32'(ovr), 32'(exp_ovr));
        check("pushpop_full", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
        for (int k = 0; k < DEPTH; k++) check_head("drain");
        check("drain_empty", 32'(data_valid), 0);
        check("drain_full", 32'(fifo_full), 0);

        // Reset during data bit 3 with one unread word in the FIFO.
        send_frame(9'h03C, 8, 0, 0, 0, 8, 0, 1, 1, -1, 1);
        repeat (8) tick();
        data_len = 4'd8; par_en = 1'b0; stp2 = 1'b0; prescale = 6'd8;
        rx_in = 1'b0;
        repeat (8) tick();
        for (int b = 0; b < 3; b++) begin
            rx_in = 1'(b & 1);
            repeat (8) tick();
        end
        rx_in = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        exp_ovr = 1'b0;
        check("midrst_p_data", 32'(p_data), 0);
        check("midrst_valid", 32'(data_valid), 0);
        check("midrst_par_err", 32'(par_err), 0);
        check("midrst_stp_err", 32'(stp_err), 0);
        check("midrst_full", 32'(fifo_full), 0);
        check("midrst_ovr", 32'(ovr), 0);
        rst = 1'b0;
        repeat (48) tick();
        check("midrst_idle", 32'(data_valid), 0);
        send_frame(9'h05A, 8, 0, 0, 0, 8, 0, 1, 1, -1, 1);
        repeat (8) tick();
        check_head("after_rst_5a");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
